// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cpu_pkg
// Description : Shared cycle-state, opcode-class and helper definitions for
//               the 16-bit Harvard CPU (sequencer, ALU, register file).
// Revision    : 1.0 - initial release
// ============================================================================
package cpu_pkg;

    // One-hot cycle state encodings; all-zero marks the halted machine
    localparam logic [2:0] ST_FETCH = 3'b001;
    localparam logic [2:0] ST_EXEC1 = 3'b010;
    localparam logic [2:0] ST_EXEC2 = 3'b100;
    localparam logic [2:0] ST_HALT  = 3'b000;

    // ALU-class load opcode (inst[15:12])
    localparam logic [3:0] OP_LDR   = 4'b1101;

    // Control-class sub-opcodes (inst[14:12] when inst[15] = 0)
    localparam logic [2:0] CTL_MOV  = 3'b000;
    localparam logic [2:0] CTL_JMP  = 3'b010;
    localparam logic [2:0] CTL_JZ   = 3'b011;
    localparam logic [2:0] CTL_HALT = 3'b100;

    typedef enum logic [2:0] {
        S_HALT  = ST_HALT,
        S_FETCH = ST_FETCH,
        S_EXEC1 = ST_EXEC1,
        S_EXEC2 = ST_EXEC2
    } seq_state_t;

    // Next-PC source selection
    typedef enum logic [1:0] {
        PC_HOLD = 2'd0,
        PC_INC  = 2'd1,
        PC_REL  = 2'd2
    } pc_sel_t;

    // Sign-extend an 8-bit branch offset to PC width
    function automatic logic [15:0] sext8(input logic [7:0] value);
        return {{8{value[7]}}, value};
    endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : fetch_sequencer_if
// Description : Memory / datapath bundle of the fetch sequencer. The master
//               side is the sequencer, the slave side is memory + datapath.
// Revision    : 1.0 - initial release
// ============================================================================
interface fetch_sequencer_if;
    logic        run;
    logic [15:0] imem_data;
    logic        dmem_ready;
    logic        z_flag;
    logic [15:0] pc;
    logic [15:0] inst;
    logic [2:0]  state;
    logic        halted;

    modport master (
        input  run, imem_data, dmem_ready, z_flag,
        output pc, inst, state, halted
    );

    modport slave (
        output run, imem_data, dmem_ready, z_flag,
        input  pc, inst, state, halted
    );
endinterface
`default_nettype wire

// File: rtl/fetch_sequencer_pc_next.sv
`default_nettype none
// ============================================================================
// Module      : pc_next
// Description : Combinational next-PC selection: hold, increment, or add a
//               sign-extended 8-bit offset. All arithmetic wraps modulo 2^16.
// Revision    : 1.0 - initial release
// ============================================================================
module pc_next
    import cpu_pkg::*;
(
    input  wire logic [15:0] i_pc,
    input  pc_sel_t          i_sel,
    input  wire logic [7:0]  i_offset,
    output logic [15:0]      o_pc_next
);

    // Select the next program counter; 16-bit adders wrap naturally
    always_comb begin
        o_pc_next = i_pc;
        case (i_sel)
            PC_INC:  o_pc_next = i_pc + 16'd1;
            PC_REL:  o_pc_next = i_pc + sext8(i_offset);
            default: o_pc_next = i_pc;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/fetch_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : fetch_sequencer
// Description : Instruction fetch / control sequencer. Owns PC and IR,
//               sequences FETCH / EXEC1 / EXEC2 / HALT, resolves jumps and
//               stretches loads until data memory is ready.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_sequencer
    import cpu_pkg::*;
#(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  wire logic          clk,
    input  wire logic          rst,
    fetch_sequencer_if.master  bus
);

    seq_state_t  r_state;
    seq_state_t  w_state_nxt;
    logic [15:0] r_pc;
    logic [15:0] r_inst;
    logic [15:0] w_pc_nxt;
    pc_sel_t     w_pc_sel;
    logic        w_load_ir;
    logic        w_is_ldr;
    logic        w_is_halt;
    logic        w_jump_taken;

    // Decode the latched instruction; only meaningful in EXEC1
    always_comb begin
        w_is_ldr     = (r_inst[15:12] == OP_LDR);
        w_is_halt    = !r_inst[15] && (r_inst[14:12] == CTL_HALT);
        w_jump_taken = !r_inst[15] &&
                       ((r_inst[14:12] == CTL_JMP) ||
                        ((r_inst[14:12] == CTL_JZ) && bus.z_flag));
    end

    // Next-state, PC source and IR load selection
    always_comb begin
        w_state_nxt = r_state;
        w_pc_sel    = PC_HOLD;
        w_load_ir   = 1'b0;
        case (r_state)
            S_FETCH: begin
                if (bus.run) begin
                    w_load_ir   = 1'b1;
                    w_pc_sel    = PC_INC;
                    w_state_nxt = S_EXEC1;
                end
            end
            S_EXEC1: begin
                if (w_is_ldr) begin
                    w_state_nxt = S_EXEC2;
                end else if (w_is_halt) begin
                    w_state_nxt = S_HALT;
                end else begin
                    // Offset is relative to the already-incremented PC
                    if (w_jump_taken) begin
                        w_pc_sel = PC_REL;
                    end
                    w_state_nxt = S_FETCH;
                end
            end
            S_EXEC2: begin
                if (bus.dmem_ready) begin
                    w_state_nxt = S_FETCH;
                end
            end
            S_HALT: begin
                w_state_nxt = S_HALT;
            end
            default: begin
                w_state_nxt = S_FETCH;
            end
        endcase
    end

    pc_next u_pc_next (
        .i_pc      (r_pc),
        .i_sel     (w_pc_sel),
        .i_offset  (r_inst[7:0]),
        .o_pc_next (w_pc_nxt)
    );

    // State, PC and IR registers with asynchronous reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_FETCH;
            r_pc    <= RESET_PC;
            r_inst  <= 16'h0000;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
            if (w_load_ir) begin
                r_inst <= bus.imem_data;
            end
        end
    end

    assign bus.pc     = r_pc;
    assign bus.inst   = r_inst;
    assign bus.state  = r_state;
    assign bus.halted = (r_state == S_HALT);

endmodule
`default_nettype wire

// File: doc/fetch_sequencer.md
# fetch_sequencer

Instruction fetch and control sequencer for the 16-bit Harvard, non-pipelined CPU. It owns the program counter and instruction register, and fetches from instruction memory. It generates the one-hot cycle state (fetch / exec1 / exec2) and the latched instruction word that the datapath ALU consumes. It also resolves control-class instructions (jumps, halt) and stretches load execution until data memory responds.

## Interface
Parameters:
- RESET_PC, 16'h0000, PC value loaded on reset

Ports:
- clk  input  1  system clock, rising-edge
- rst  input  1  reset; asynchronous, active-high
- run  input  1  fetch enable; when low, sequencer idles in FETCH
- imem_data  input  16  instruction memory read data for address pc (combinational memory)
- dmem_ready  input  1  data memory load-complete strobe, sampled in EXEC2
- z_flag  input  1  datapath zero flag, sampled in EXEC1
- pc  output  16  program counter; drives instruction memory address
- inst  output  16  instruction register, to ALU/datapath
- state  output  3  one-hot cycle state: bit0 FETCH, bit1 EXEC1, bit2 EXEC2; 3'b000 when halted
- halted  output  1  high in HALT state

## Operation
Reset values:
- pc = RESET_PC, inst = 16'h0000, state = 3'b001, halted = 0.

Instruction classes:
- inst[15]=1: ALU class.
  - inst[15:12]=4'b1101 is LDR and takes EXEC2.
  - All other ALU-class instructions are single-exec.
- inst[15]=0: control class, decoded on inst[14:12]:
  - 000 register/immediate move: single exec, no PC effect.
  - 010 JMP: pc <= pc + sext(inst[7:0]).
  - 011 JZ: same as JMP, only if z_flag=1.
  - 100 HALT.
  - Others: treated as NOP.

States:
- FETCH
  - If run=1: inst <= imem_data, pc <= pc+1, go to EXEC1.
  - If run=0: hold; pc and inst unchanged.
- EXEC1
  - LDR → EXEC2.
  - HALT → HALT.
  - Taken JMP/JZ → pc <= pc + sext(inst[7:0]), then FETCH. The offset is relative to the already-incremented pc.
  - Anything else → FETCH.
- EXEC2
  - dmem_ready=1 → FETCH.
  - Otherwise hold in EXEC2 indefinitely. ALU write-enable stays asserted; repeated writes of identical data are accepted.
- HALT
  - state=3'b000, halted=1; pc and inst frozen.
  - Exit only via rst.

Arithmetic:
- pc arithmetic is 16-bit modulo: FFFF+1 = 0000, and relative targets wrap both directions.
- sext replicates inst[7], giving a branch range of -128..+127.

Boundary conditions:
- run is sampled only in FETCH; deasserting run mid-instruction lets the instruction complete.
- z_flag is ignored for non-JZ instructions.
- dmem_ready outside EXEC2 is ignored.
- rst asserted in any state (including mid-EXEC2 wait) forces reset values immediately, without waiting for a clock edge.

## Timing
- Outputs pc, inst, state and halted are registered; halted is decoded from the registered state.
- Non-load instruction: 2 cycles (FETCH, EXEC1).
- LDR: 3 + N cycles, where N is the number of EXEC2 cycles with dmem_ready=0.
- Taken jump: new pc is visible the cycle after EXEC1, which is the next FETCH. No delay slot.
- imem_data must be valid within the FETCH cycle for the current pc.
- rst deassertion: the first FETCH occurs on the first rising edge where run=1.

## Structure
- Shared package `cpu_pkg`:
  - State one-hot constants: ST_FETCH=3'b001, ST_EXEC1=3'b010, ST_EXEC2=3'b100, ST_HALT=3'b000.
  - Opcode-class constants: OP_LDR=4'b1101, CTL_MOV, CTL_JMP, CTL_JZ, CTL_HALT.
  - Shared with the ALU and register file.
- One sub-module, `pc_next`: combinational next-PC selection (hold / +1 / +sext offset) with modulo wrap.
- State register, IR and PC register stay in the top block.

## Test plan
- Reset/idle: rst pulse with run=0 → pc=0000, inst=0000, state=001 held for 10 cycles.
- Straight-line: imem returns 8000 (ADD) at pc 0 and 9000 at pc 1 → states 001,010,001,010; pc 0→1→2; inst latched 8000 then 9000.
- LDR wait: LDR D000 at pc 5, dmem_ready low 3 cycles then high → EXEC2 held 4 cycles total; 6-cycle instruction; pc=6 at the next FETCH.
- Branches:
  - JMP 20FE at pc 10 → pc=11 after fetch, then 000F.
  - JZ 3005 with z_flag=0 → pc continues sequentially.
  - JZ 3005 with z_flag=1 → pc = pc+1+5.
- Wrap: pc FFFF, fetch → pc=0000; JMP 207F at pc 0xFFF0 → target 0x0070.
- HALT and async reset: 4000 → state 000, halted=1 for 20 cycles, run toggling has no effect. Asserting rst mid-cycle (during HALT and during an EXEC2 wait) restores reset values before the next clock edge.
